// File: rtl/axi_burst_read_controller.sv
// AXI4 read-channel slave for a single-port BRAM with READ_LATENCY cycles of read latency.
// Serves one INCR burst (1..256 beats) at a time; a credit-limited FIFO absorbs rready stalls.
module axi_burst_read_controller #(
  parameter  int ADDR_WIDTH   = 12,
  parameter  int DATA_WIDTH   = 32,
  parameter  int ID_WIDTH     = 4,
  parameter  int READ_LATENCY = 2,
  localparam int BYTE_BITS    = $clog2(DATA_WIDTH / 8),
  localparam int WADDR_W      = ADDR_WIDTH - BYTE_BITS
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [ID_WIDTH-1:0]   s_arid,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  bram_en,
  output logic [WADDR_W-1:0]    bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata
);

  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, state_next;
  logic                    arready_q;
  logic [WADDR_W-1:0]      ptr;
  logic [8:0]              beats_left;
  logic [ID_WIDTH-1:0]     id_q;
  logic [READ_LATENCY-1:0] pipe_v, pipe_last;
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W:0]          occupancy;
  logic                    ar_hs, issue, push, pop, credit_ok;
  logic                    unused_araddr;

  // Byte-offset bits of the start address carry no information for full-width beats.
  assign unused_araddr = ^s_araddr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit = beats still in the BRAM pipeline plus beats already buffered.
  always_comb begin
    occupancy = {1'b0, count};
    for (int i = 0; i < READ_LATENCY; i++) occupancy = occupancy + (CNT_W + 1)'(pipe_v[i]);
  end

  assign credit_ok = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign s_rvalid  = (count != '0);
  assign pop       = s_rvalid && s_rready;
  assign push      = pipe_v[READ_LATENCY-1];
  assign ar_hs     = (state == IDLE) && s_arvalid && arready_q;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE:  if (ar_hs) state_next = ISSUE;
      ISSUE: if (credit_ok) begin
        issue = 1'b1;
        if (beats_left == 9'd1) state_next = DRAIN;
      end
      DRAIN: if (pop && fifo_last[rd_ptr]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state      <= IDLE;
      arready_q  <= 1'b0;
      ptr        <= '0;
      beats_left <= '0;
      id_q       <= '0;
      pipe_v     <= '0;
      pipe_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state     <= state_next;
      arready_q <= (state_next == IDLE);
      if (ar_hs) begin
        id_q       <= s_arid;
        ptr        <= s_araddr[ADDR_WIDTH-1:BYTE_BITS];
        beats_left <= {1'b0, s_arlen} + 9'd1;
      end else if (issue) begin
        ptr        <= ptr + 1'b1;
        beats_left <= beats_left - 9'd1;
      end
      pipe_v[0]    <= issue;
      pipe_last[0] <= issue && (beats_left == 9'd1);
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; count gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bram_rdata;
      fifo_last[wr_ptr] <= pipe_last[READ_LATENCY-1];
    end
  end

  assign s_arready = arready_q;
  assign s_rdata   = s_rvalid ? fifo_data[rd_ptr] : '0;
  assign s_rid     = s_rvalid ? id_q : '0;
  assign s_rlast   = s_rvalid && fifo_last[rd_ptr];
  assign s_rresp   = 2'b00;
  assign bram_en   = issue;
  assign bram_addr = ptr;

endmodule

// File: tb/tb_axi_burst_read_controller.sv
// Bench for axi_burst_read_controller: three instances at READ_LATENCY 1, 2 and 4 against
// a transaction-level model (expected beat k of a burst = mem[start + k], with arithmetic timing).
module tb_axi_burst_read_controller;
  localparam int NL = 3;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int WW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn;
  logic          arvalid [NL];
  logic [AW-1:0] araddr  [NL];
  logic [7:0]    arlen   [NL];
  logic [IW-1:0] arid    [NL];
  logic          rready  [NL];
  logic          arready [NL];
  logic          rvalid  [NL];
  logic [DW-1:0] rdata   [NL];
  logic [IW-1:0] rid     [NL];
  logic [1:0]    rresp   [NL];
  logic          rlast   [NL];
  logic          bram_en [NL];
  logic [WW-1:0] bram_addr  [NL];
  logic [DW-1:0] bram_rdata [NL];

  function automatic logic [DW-1:0] mem_word(input logic [WW-1:0] a);
    return {8'hC3, 2'b00, a, 2'b00, ~a};
  endfunction

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : (l == 1) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [WW-1:0] a_sr [L];
    logic          v_sr [L];

    axi_burst_read_controller #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .READ_LATENCY(L)
    ) dut (
      .clk(clk), .aresetn(aresetn),
      .s_arvalid(arvalid[g]), .s_arready(arready[g]), .s_araddr(araddr[g]),
      .s_arlen(arlen[g]), .s_arid(arid[g]),
      .s_rvalid(rvalid[g]), .s_rready(rready[g]), .s_rdata(rdata[g]),
      .s_rid(rid[g]), .s_rresp(rresp[g]), .s_rlast(rlast[g]),
      .bram_en(bram_en[g]), .bram_addr(bram_addr[g]), .bram_rdata(bram_rdata[g])
    );

    // BRAM model: data for a read issued in cycle C is driven only during C+L.
    always @(posedge clk) begin
      a_sr[0] <= bram_addr[g];
      v_sr[0] <= bram_en[g];
      for (int k = 1; k < L; k++) begin
        a_sr[k] <= a_sr[k-1];
        v_sr[k] <= v_sr[k-1];
      end
    end
    assign bram_rdata[g] = v_sr[L-1] ? mem_word(a_sr[L-1]) : 32'hDEAD_BEEF;
  end

  int checks, errors, cyc;
  bit model_on, rst_prev;

  bit            busy      [NL];
  logic [WW-1:0] base      [NL];
  int            nbeats    [NL];
  logic [IW-1:0] mid       [NL];
  int            issued    [NL];
  int            popped    [NL];
  int            t_hs      [NL];
  bit            full_rate [NL];
  bit            stall     [NL];
  logic [DW-1:0] p_data    [NL];
  logic [IW-1:0] p_id      [NL];
  logic          p_last    [NL];

  logic [WW-1:0] addr_log  [NL][256];
  int            issue_cyc [NL][256];
  int            pop_cyc   [NL][256];
  logic [DW-1:0] data_log  [NL][256];
  logic          last_log  [NL][256];
  logic [IW-1:0] id_log    [NL][256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic lane_cycle(input int l, input string n);
    logic [WW-1:0] ea;
    int  k;
    bit  done;
    done = 1'b0;
    check({n, " arready"}, arready[l], !busy[l]);
    check({n, " rresp"}, rresp[l], 2'b00);
    if (bram_en[l]) begin
      ea = base[l] + WW'(issued[l]);
      check({n, " issue_in_burst"}, busy[l] && (issued[l] < nbeats[l]), 1'b1);
      check({n, " credit"}, (issued[l] - popped[l]) < lat_of(l) + 2, 1'b1);
      check({n, " bram_addr"}, bram_addr[l], ea);
      if (issued[l] < 256) begin
        addr_log[l][issued[l]]  = bram_addr[l];
        issue_cyc[l][issued[l]] = cyc;
      end
      issued[l]++;
    end
    if (stall[l]) begin
      check({n, " hold_valid"}, rvalid[l], 1'b1);
      check({n, " hold_outputs"}, {rdata[l], rid[l], rlast[l]}, {p_data[l], p_id[l], p_last[l]});
    end
    if (busy[l] && !rready[l]) full_rate[l] = 1'b0;
    if (!rvalid[l]) begin
      check({n, " idle_zero"}, {rdata[l], rid[l], rlast[l]}, '0);
    end else begin
      k = popped[l];
      ea = base[l] + WW'(k);
      check({n, " beat_expected"}, busy[l] && (k < issued[l]), 1'b1);
      check({n, " rdata"}, rdata[l], mem_word(ea));
      check({n, " rlast"}, rlast[l], k == nbeats[l] - 1);
      check({n, " rid"}, rid[l], mid[l]);
      if (rready[l]) begin
        if (k < 256) begin
          pop_cyc[l][k]  = cyc;
          data_log[l][k] = rdata[l];
          last_log[l][k] = rlast[l];
          id_log[l][k]   = rid[l];
        end
        if (full_rate[l]) check({n, " beat_cycle"}, cyc, t_hs[l] + 2 + lat_of(l) + k);
        popped[l]++;
        if (popped[l] == nbeats[l]) done = 1'b1;
      end
    end
    stall[l]  = rvalid[l] && !rready[l];
    p_data[l] = rdata[l];
    p_id[l]   = rid[l];
    p_last[l] = rlast[l];
    if (done) busy[l] = 1'b0;
    if (aresetn && arvalid[l] && arready[l]) begin
      busy[l]      = 1'b1;
      base[l]      = araddr[l][AW-1:2];
      nbeats[l]    = int'(arlen[l]) + 1;
      mid[l]       = arid[l];
      issued[l]    = 0;
      popped[l]    = 0;
      t_hs[l]      = cyc;
      full_rate[l] = 1'b1;
    end
  endtask

  task automatic compare();
    string n;
    if (model_on) begin
      for (int l = 0; l < NL; l++) begin
        n = $sformatf("L%0d", lat_of(l));
        if (rst_prev) begin
          check({n, " rst_arready"}, arready[l], 1'b0);
          check({n, " rst_rvalid"}, rvalid[l], 1'b0);
          check({n, " rst_bram_en"}, bram_en[l], 1'b0);
          check({n, " rst_outputs"}, {rdata[l], rid[l], rlast[l], rresp[l], bram_addr[l]}, '0);
          busy[l]   = 1'b0;
          issued[l] = 0;
          popped[l] = 0;
          stall[l]  = 1'b0;
        end else begin
          lane_cycle(l, n);
        end
      end
    end
    rst_prev = !aresetn;
    if (!aresetn) model_on = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_burst(input int l, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [IW-1:0] id, input bit rnd, input int abort_after);
    int n;
    arvalid[l] = 1'b1;
    araddr[l]  = a;
    arlen[l]   = len;
    arid[l]    = id;
    rready[l]  = 1'b1;
    n = 0;
    while (!arready[l] && n < 20) begin
      step();
      n++;
    end
    check("ar_wait_timeout", arready[l], 1'b1);
    step();
    arvalid[l] = 1'b0;
    n = 0;
    while (busy[l] && n < 3000) begin
      if (abort_after > 0 && popped[l] == abort_after) begin
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        return;
      end
      rready[l] = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      step();
      n++;
    end
    check("burst_timeout", busy[l], 1'b0);
    rready[l] = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int prev_pop;
    checks = 0; errors = 0; cyc = 0;
    model_on = 1'b0; rst_prev = 1'b0;
    aresetn = 1'b0;
    for (int l = 0; l < NL; l++) begin
      arvalid[l] = 1'b0; araddr[l] = '0; arlen[l] = '0; arid[l] = '0; rready[l] = 1'b0;
      busy[l] = 1'b0; stall[l] = 1'b0; issued[l] = 0; popped[l] = 0;
    end
    repeat (3) step();
    aresetn = 1'b1;
    step();

    // READ_LATENCY = 2: single beat
    run_burst(1, 12'h010, 8'd0, 4'd5, 1'b0, 0);
    check("single_addr", addr_log[1][0], 10'h004);
    check("single_issue_cycle", issue_cyc[1][0], t_hs[1] + 1);
    check("single_first_cycle", pop_cyc[1][0], t_hs[1] + 4);
    check("single_data", data_log[1][0], 32'hC30043FB);
    check("single_last", last_log[1][0], 1'b1);
    check("single_id", id_log[1][0], 4'd5);
    check("single_done_cycle", cyc, t_hs[1] + 5);
    check("single_arready_after", arready[1], 1'b1);

    // Back-to-back 8-beat burst at full rate
    prev_pop = pop_cyc[1][0];
    run_burst(1, 12'h100, 8'd7, 4'd3, 1'b0, 0);
    check("b2b_handshake", t_hs[1], prev_pop + 1);
    check("b8_last_cycle", pop_cyc[1][7], t_hs[1] + 11);
    check("b8_last_data", data_log[1][7], 32'hC30473B8);
    check("b8_last7", last_log[1][7], 1'b1);
    check("b8_last6", last_log[1][6], 1'b0);

    run_burst(1, 12'h204, 8'd15, 4'hA, 1'b1, 0);
    check("bp_beats", popped[1], 16);

    run_burst(1, 12'hFF8, 8'd3, 4'h7, 1'b0, 0);
    check("wrap_a0", addr_log[1][0], 10'h3FE);
    check("wrap_a1", addr_log[1][1], 10'h3FF);
    check("wrap_a2", addr_log[1][2], 10'h000);
    check("wrap_a3", addr_log[1][3], 10'h001);

    run_burst(1, 12'h040, 8'd15, 4'h2, 1'b0, 3);
    check("rst_arready_rise", arready[1], 1'b1);
    run_burst(1, 12'h080, 8'd3, 4'h9, 1'b0, 0);
    check("post_rst_first", data_log[1][0], 32'hC30203DF);
    check("post_rst_id", id_log[1][0], 4'h9);

    // Latency sweep
    run_burst(0, 12'h300, 8'd7, 4'd1, 1'b0, 0);
    check("l1_first_cycle", pop_cyc[0][0], t_hs[0] + 3);
    check("l1_last_cycle", pop_cyc[0][7], t_hs[0] + 10);
    run_burst(0, 12'h120, 8'd15, 4'd2, 1'b1, 0);
    check("l1_bp_beats", popped[0], 16);
    run_burst(2, 12'h300, 8'd7, 4'd6, 1'b0, 0);
    check("l4_first_cycle", pop_cyc[2][0], t_hs[2] + 6);
    check("l4_last_cycle", pop_cyc[2][7], t_hs[2] + 13);
    run_burst(2, 12'h120, 8'd15, 4'd8, 1'b1, 0);
    check("l4_bp_beats", popped[2], 16);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
